// File: rtl/seg_rtc_clock_pkg.sv
// seg_rtc_clock_pkg: shared segment patterns, mode encodings and BCD helper
package seg_rtc_clock_pkg;
  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SET_H = 2'b01,
    MODE_SET_M = 2'b10,
    MODE_SET_S = 2'b11
  } mode_e;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [3:0] CODE_DASH = 4'hA;
  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'hF6, 8'hFE, 8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/seg_rtc_clock_seg7_decode.sv
// seg7_decode: BCD digit (or dash code) to {a..g,dp} segments with blanking
module seg7_decode
  import seg_rtc_clock_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb
    seg = blank ? SEG_BLANK :
          (code == CODE_DASH) ? SEG_DASH :
          (code <= 4'd9) ? SEG_DIGIT[code] : SEG_BLANK;
endmodule

// File: rtl/seg_rtc_clock.sv
// seg_rtc_clock: BCD HH:MM:SS clock with setting, 12/24h display, blink, chime and 7-seg scan
module seg_rtc_clock
  import seg_rtc_clock_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] set_mode,
  input  logic       btn_inc,
  input  logic       mode_12h,
  output logic [7:0] seg_data1,
  output logic [7:0] seg_data2,
  output logic [7:0] seg_which,
  output logic       chime
);
  localparam int PRE = CLK_HZ / TICK_HZ;
  localparam int DWELL = CLK_HZ / (4 * SCAN_HZ);
  localparam int BLINK = CLK_HZ / 4;
  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;
  mode_e mode;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0] idx;
  logic phase, tick;
  logic [7:0] hh, mm, ss;
  logic [4:0] hb, h12;
  logic [3:0] ht, ho, code1, code2;
  logic pm, bh, bm, bs, blank1, blank2;
  logic [7:0] seg1, seg2;
  assign mode = mode_e'(set_mode);
  assign tick = pre_cnt == PW'(PRE - 1);
  // Prescaler only runs in run mode, so each return to run starts a full tick period
  always_ff @(posedge clk or negedge rst)
    if (!rst) pre_cnt <= '0;
    else pre_cnt <= (mode != MODE_RUN || tick) ? '0 : pre_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scan_cnt <= '0;
      idx <= '0;
      blink_cnt <= '0;
      phase <= 1'b0;
    end else begin
      scan_cnt <= (scan_cnt == DW'(DWELL - 1)) ? '0 : scan_cnt + 1'b1;
      idx <= (scan_cnt == DW'(DWELL - 1)) ? idx + 2'd1 : idx;
      blink_cnt <= (blink_cnt == BW'(BLINK - 1)) ? '0 : blink_cnt + 1'b1;
      phase <= (blink_cnt == BW'(BLINK - 1)) ? ~phase : phase;
    end
  // A tick already in flight wins over a same-cycle edit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hh <= '0;
      mm <= '0;
      ss <= '0;
      chime <= 1'b0;
    end else begin
      chime <= tick && ss == 8'h59 && mm == 8'h59;
      if (tick) begin
        ss <= bcd_inc(ss, 8'h59);
        if (ss == 8'h59) mm <= bcd_inc(mm, 8'h59);
        if (ss == 8'h59 && mm == 8'h59) hh <= bcd_inc(hh, 8'h23);
      end else if (btn_inc) begin
        if (mode == MODE_SET_H) hh <= bcd_inc(hh, 8'h23);
        if (mode == MODE_SET_M) mm <= bcd_inc(mm, 8'h59);
        if (mode == MODE_SET_S) ss <= '0;
      end
    end
  always_comb begin
    hb = {1'b0, hh[7:4]} * 5'd10 + {1'b0, hh[3:0]};
    h12 = (hb == 5'd0) ? 5'd12 : (hb > 5'd12) ? hb - 5'd12 : hb;
    ht = mode_12h ? ((h12 >= 5'd10) ? 4'd1 : 4'd0) : hh[7:4];
    ho = mode_12h ? ((h12 >= 5'd10) ? 4'(h12 - 5'd10) : h12[3:0]) : hh[3:0];
    pm = mode_12h && hb >= 5'd12;
    bh = phase && mode == MODE_SET_H;
    bm = phase && mode == MODE_SET_M;
    bs = phase && mode == MODE_SET_S;
  end
  // Left group shows digit idx+4, right group digit idx
  always_comb begin
    code1 = CODE_DASH;
    blank1 = 1'b0;
    code2 = CODE_DASH;
    blank2 = 1'b0;
    case (idx)
      2'd0: begin
        code1 = mm[7:4];
        blank1 = bm;
        code2 = ss[3:0];
        blank2 = bs;
      end
      2'd1: begin
        code2 = ss[7:4];
        blank2 = bs;
      end
      2'd2: begin
        code1 = ho;
        blank1 = bh;
      end
      default: begin
        code1 = ht;
        blank1 = bh || (mode_12h && ht == 4'd0);
        code2 = mm[3:0];
        blank2 = bm;
      end
    endcase
  end
  seg7_decode u_dec1 (.code(code1), .blank(blank1), .seg(seg1));
  seg7_decode u_dec2 (.code(code2), .blank(blank2), .seg(seg2));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      seg_which <= '0;
      seg_data1 <= '0;
      seg_data2 <= '0;
    end else begin
      seg_which <= 8'h11 << idx;
      seg_data1 <= seg1;
      seg_data2 <= seg2 | {7'd0, idx == 2'd0 && pm};
    end
endmodule

// File: tb/tb_seg_rtc_clock.sv
// tb_seg_rtc_clock: table, directed and randomized checks against a seconds-of-day model
module tb_seg_rtc_clock;
  logic clk = 1'b0, rst = 1'b0, btn_inc = 1'b0, mode_12h = 1'b0;
  logic [1:0] set_mode = 2'b00;
  logic [7:0] seg_data1, seg_data2, seg_which;
  logic chime;
  int total = 0, bad = 0;
  int h = 0, m = 0, s = 0;
  bit m12 = 0;
  int chime_cnt = 0, chime_exp = 0, chime_run = 0, chime_wide = 0;
  int cyc;
  logic [7:0] dig [8];

  seg_rtc_clock #(.CLK_HZ(400), .TICK_HZ(1), .SCAN_HZ(25)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .btn_inc(btn_inc), .mode_12h(mode_12h),
    .seg_data1(seg_data1), .seg_data2(seg_data2), .seg_which(seg_which), .chime(chime)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk) begin
    if (chime) chime_cnt++;
    chime_run = chime ? chime_run + 1 : 0;
    if (chime_run > 1) chime_wide++;
  end

  typedef struct {
    logic [7:0] which;
    logic [7:0] d1;
    logic [7:0] d2;
  } scan_vec_t;
  scan_vec_t vec [4];

  function automatic logic [7:0] seg_of(int d);
    case (d)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_dig(int k);
    int hd;
    hd = m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    case (k)
      7: return (m12 && hd < 10) ? 8'h00 : seg_of(hd / 10);
      6: return seg_of(hd % 10);
      5, 2: return 8'h02;
      4: return seg_of(m / 10);
      3: return seg_of(m % 10);
      1: return seg_of(s / 10);
      default: return seg_of(s % 10) | ((m12 && h >= 12) ? 8'h01 : 8'h00);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic grab();
    for (int k = 0; k < 8; k++) dig[k] = 'x;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      case (seg_which)
        8'h11: begin dig[4] = seg_data1; dig[0] = seg_data2; end
        8'h22: begin dig[5] = seg_data1; dig[1] = seg_data2; end
        8'h44: begin dig[6] = seg_data1; dig[2] = seg_data2; end
        8'h88: begin dig[7] = seg_data1; dig[3] = seg_data2; end
        default: chk("scan_which", {24'd0, seg_which}, 32'h11);
      endcase
    end
  endtask

  task automatic check_frame(input string tag);
    grab();
    for (int k = 0; k < 8; k++) chk($sformatf("%s_digit%0d", tag, k), {24'd0, dig[k]}, {24'd0, exp_dig(k)});
  endtask

  task automatic show(input string tag);
    @(negedge clk) set_mode = 2'b00;
    check_frame(tag);
    set_mode = 2'b11;
  endtask

  task automatic press(input logic [1:0] md, input int n);
    @(negedge clk) set_mode = md;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) btn_inc = 1'b1;
      @(negedge clk) btn_inc = 1'b0;
      if (md == 2'b01) h = (h + 1) % 24;
      if (md == 2'b10) m = (m + 1) % 60;
      if (md == 2'b11) s = 0;
    end
  endtask

  task automatic run_ticks(input string tag, input int n);
    int t;
    @(negedge clk) set_mode = 2'b00;
    repeat (400 * n + 20) @(negedge clk);
    t = h * 3600 + m * 60 + s;
    for (int i = 0; i < n; i++) begin
      t = (t + 1) % 86400;
      if (t % 3600 == 0) chime_exp++;
    end
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    check_frame(tag);
    set_mode = 2'b11;
  endtask

  initial begin
    int c0, op, k;
    bit blank;
    vec[0] = '{8'h11, 8'hFC, 8'hFC};
    vec[1] = '{8'h22, 8'h02, 8'hFC};
    vec[2] = '{8'h44, 8'hFC, 8'h02};
    vec[3] = '{8'h88, 8'hFC, 8'hFC};
    // reset held, then scan table after release
    repeat (3) begin
      @(negedge clk);
      chk("rst_which", {24'd0, seg_which}, 0);
      chk("rst_d1", {24'd0, seg_data1}, 0);
      chk("rst_d2", {24'd0, seg_data2}, 0);
      chk("rst_chime", {31'd0, chime}, 0);
    end
    rst = 1'b1;
    @(posedge clk);
    for (int e = 0; e < 4; e++)
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("scan%0d_which", e), {24'd0, seg_which}, {24'd0, vec[e].which});
        chk($sformatf("scan%0d_d1", e), {24'd0, seg_data1}, {24'd0, vec[e].d1});
        chk($sformatf("scan%0d_d2", e), {24'd0, seg_data2}, {24'd0, vec[e].d2});
      end
    // 23:59:00 rolls to 00:00:00 with a single chime
    press(2'b01, 23);
    press(2'b10, 59);
    press(2'b11, 1);
    c0 = chime_cnt;
    run_ticks("roll", 60);
    chk("roll_chime_count", chime_cnt - c0, 1);
    chk("roll_chime_width", chime_wide, 0);
    // minute wrap without hour carry, seconds frozen while setting
    run_ticks("pre_wrap", 2);
    press(2'b10, (59 - m + 60) % 60);
    press(2'b10, 1);
    repeat (1000) @(negedge clk);
    show("min_wrap");
    // 12h display
    m12 = 1;
    mode_12h = 1'b1;
    press(2'b01, (13 - h + 24) % 24);
    show("h13");
    chk("h13_tens_blank", {24'd0, dig[7]}, 0);
    chk("h13_ones", {24'd0, dig[6]}, 32'h60);
    chk("h13_dp", {31'd0, dig[0][0]}, 1);
    press(2'b01, 11);
    show("h0");
    chk("h0_tens", {24'd0, dig[7]}, 32'h60);
    chk("h0_ones", {24'd0, dig[6]}, 32'hDA);
    chk("h0_dp", {31'd0, dig[0][0]}, 0);
    // hour field blinks in set-hours mode
    m12 = 0;
    mode_12h = 1'b0;
    press(2'b01, (12 - h + 24) % 24);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      blank = ((cyc - 1) / 100) % 2 == 1;
      k = (seg_which == 8'h11) ? 0 : (seg_which == 8'h22) ? 1 : (seg_which == 8'h44) ? 2 : 3;
      chk("blink_d1", {24'd0, seg_data1}, (k >= 2 && blank) ? 0 : {24'd0, exp_dig(k + 4)});
      chk("blink_d2", {24'd0, seg_data2}, {24'd0, exp_dig(k)});
    end
    // randomized edits and runs
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin press(2'b01, $urandom_range(1, 30)); show("rnd_h"); end
        1: begin press(2'b10, $urandom_range(1, 70)); show("rnd_m"); end
        2: begin press(2'b11, 1); show("rnd_s"); end
        3: run_ticks("rnd_run", $urandom_range(1, 3));
        default: begin
          @(negedge clk);
          m12 = !m12;
          mode_12h = m12;
          show("rnd_12h");
        end
      endcase
    end
    chk("chime_total", chime_cnt, chime_exp);
    // async reset mid-frame at 12:34:56
    m12 = 0;
    mode_12h = 1'b0;
    press(2'b01, (12 - h + 24) % 24);
    press(2'b10, (34 - m + 60) % 60);
    press(2'b11, 1);
    run_ticks("t123456", 56);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_which", {24'd0, seg_which}, 0);
    chk("arst_d1", {24'd0, seg_data1}, 0);
    chk("arst_d2", {24'd0, seg_data2}, 0);
    chk("arst_chime", {31'd0, chime}, 0);
    @(negedge clk) rst = 1'b1;
    h = 0;
    m = 0;
    s = 0;
    c0 = chime_cnt;
    show("after_rst");
    chk("after_rst_chime", chime_cnt - c0, 0);
    chk("chime_width_all", chime_wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
